// File: rtl/nano_pkg.sv
// Shared types and sizing for the NanoCPU memory responder and program loader.
package nano_pkg;

  localparam int NANO_ADDR_W = 8;
  localparam int NANO_DATA_W = 16;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    LD_HI   = 3'd1,
    LD_LO   = 3'd2,
    LD_WR   = 3'd3,
    RELEASE = 3'd4
  } LdStateType;

endpackage

// File: rtl/nano_ram.sv
// Single write port RAM with combinational read, shared by the CPU and the loader.
module nano_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              ck,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge ck) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is asynchronous so the CPU sees data in the same cycle it drives the address.
  assign rdata = mem[raddr];

endmodule

// File: rtl/nano_mem_loader.sv
// NanoCPU memory responder: CPU RAM port plus a byte-stream loader that
// fills the RAM from address 0 while holding the CPU in reset.
module nano_mem_loader
  import nano_pkg::*;
#(
  parameter int ADDR_W = NANO_ADDR_W,
  parameter int DATA_W = NANO_DATA_W
) (
  input  logic              ck,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataW,
  output logic [DATA_W-1:0] dataR,
  input  logic              ce,
  input  logic              we,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_err
);

  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

  LdStateType        state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              err_reg, err_next;
  logic              last_reg, last_next;
  logic [7:0]        hi_reg, hi_next;
  logic [7:0]        lo_reg, lo_next;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge ck) begin
    if (rst) begin
      state_reg <= RUN;
      ptr_reg   <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
      last_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      last_reg  <= last_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    err_next   = err_reg;
    last_next  = last_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    ld_ready   = 1'b0;
    cpu_hold   = 1'b0;
    case (state_reg)
      RUN: begin
        if (ld_start) begin
          state_next = LD_HI;
          ptr_next   = '0;
          count_next = '0;
          err_next   = 1'b0;
          last_next  = 1'b0;
        end
      end
      LD_HI: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
        if (ld_valid) begin
          hi_next = ld_byte;
          // A stream ending on a high byte is padded with a zero low byte and flagged.
          if (ld_last) begin
            lo_next    = 8'h00;
            err_next   = 1'b1;
            last_next  = 1'b1;
            state_next = LD_WR;
          end else begin
            state_next = LD_LO;
          end
        end
      end
      LD_LO: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
        if (ld_valid) begin
          lo_next    = ld_byte;
          last_next  = ld_last;
          state_next = LD_WR;
        end
      end
      LD_WR: begin
        cpu_hold   = 1'b1;
        ptr_next   = ptr_reg + 1'b1;
        count_next = count_reg + 1'b1;
        if (last_reg || ptr_reg == PTR_MAX) begin
          state_next = RELEASE;
          if (!last_reg) begin
            err_next = 1'b1;
          end
        end else begin
          state_next = LD_HI;
        end
      end
      RELEASE: begin
        cpu_hold   = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Write port belongs to the loader in LD_WR and to the CPU only in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = address;
    ram_wdata = dataW;
    if (!rst) begin
      if (state_reg == LD_WR) begin
        ram_we    = 1'b1;
        ram_waddr = ptr_reg;
        ram_wdata = {hi_reg, lo_reg};
      end else if (state_reg == RUN && ce && we) begin
        ram_we = 1'b1;
      end
    end
  end

  nano_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .ck    (ck),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (address),
    .rdata (ram_rdata)
  );

  assign dataR    = ce ? ram_rdata : '0;
  assign ld_count = count_reg;
  assign ld_err   = err_reg;

endmodule

// File: tb/tb_nano_mem_loader.sv
// Directed bench for nano_mem_loader: CPU access table plus loader sequences.
module tb_nano_mem_loader;

  logic        ck;
  logic        rst;
  logic [7:0]  address;
  logic [15:0] dataW;
  logic [15:0] dataR;
  logic        ce;
  logic        we;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_hold;
  logic [8:0]  ld_count;
  logic        ld_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] src [600];

  typedef struct {
    logic        ce;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] exp;
  } cpu_vec_t;

  localparam int NV = 10;
  cpu_vec_t vecs [NV];

  nano_mem_loader dut (
    .ck       (ck),
    .rst      (rst),
    .address  (address),
    .dataW    (dataW),
    .dataR    (dataR),
    .ce       (ce),
    .we       (we),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .cpu_hold (cpu_hold),
    .ld_count (ld_count),
    .ld_err   (ld_err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [15:0] exp);
    @(negedge ck);
    ce = 1'b1;
    we = 1'b0;
    address = a;
    #1;
    check(name, dataR, exp);
    ce = 1'b0;
  endtask

  // Drives src[0..nbytes-1] into the loader from ld_start until cpu_hold drops.
  task automatic do_load(input int nbytes, input bit use_last, input bit throttle,
                         output int hold_cnt, output int accepted, output int ready_bad,
                         output logic err_at_start);
    int cyc;
    bit expect_wr;
    bit prev_ready;
    bit done;
    hold_cnt = 0; accepted = 0; ready_bad = 0; cyc = 0;
    expect_wr = 0; prev_ready = 0; done = 0;
    @(negedge ck);
    ld_start = 1'b1;
    @(negedge ck);
    ld_start = 1'b0;
    err_at_start = ld_err;
    while (!done && cyc < 2000) begin
      if (cpu_hold) begin
        hold_cnt++;
        if (expect_wr && ld_ready) ready_bad++;
        prev_ready = ld_ready;
        if (accepted < nbytes && (!throttle || cyc % 2 == 0)) begin
          ld_valid = 1'b1;
          ld_byte  = src[accepted];
          ld_last  = use_last && (accepted == nbytes - 1);
        end else begin
          ld_valid = 1'b0;
          ld_last  = 1'b0;
        end
        expect_wr = 0;
        if (ld_valid && ld_ready) begin
          accepted++;
          expect_wr = (accepted % 2 == 0) || ld_last;
        end
        cyc++;
        @(negedge ck);
      end else begin
        done = 1;
        if (prev_ready) ready_bad++;
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("load_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int hold, acc, rbad;
    logic e0;

    rst = 1'b1; ce = 1'b0; we = 1'b0; address = '0; dataW = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b0, 8'h10, 16'h0000, 1'b1, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 8'h11, 16'h1111, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 8'h11, 16'h2222, 1'b1, 16'h1111};
    vecs[5] = '{1'b1, 1'b0, 8'h11, 16'h0000, 1'b1, 16'h2222};
    vecs[6] = '{1'b1, 1'b1, 8'h12, 16'h5555, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 8'h12, 16'hDEAD, 1'b1, 16'h0000};
    vecs[8] = '{1'b1, 1'b0, 8'h12, 16'h0000, 1'b1, 16'h5555};
    vecs[9] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 16'hBEEF};

    repeat (3) @(negedge ck);
    rst = 1'b0;
    #1;
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_ld_count", {23'd0, ld_count}, 32'd0);
    check("rst_ld_err",   {31'd0, ld_err},   32'd0);
    check("rst_dataR",    {16'd0, dataR},    32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge ck);
      ce = vecs[i].ce; we = vecs[i].we; address = vecs[i].addr; dataW = vecs[i].wdata;
      #1;
      if (vecs[i].chk) check($sformatf("cpu_vec%0d", i), {16'd0, dataR}, {16'd0, vecs[i].exp});
    end
    @(negedge ck);
    ce = 1'b0; we = 1'b0;

    // Four-word load with ld_valid held high.
    src[0] = 8'h12; src[1] = 8'h34; src[2] = 8'h56; src[3] = 8'h78;
    src[4] = 8'h9A; src[5] = 8'hBC; src[6] = 8'hDE; src[7] = 8'hF0;
    do_load(8, 1'b1, 1'b0, hold, acc, rbad, e0);
    check("w4_hold",     hold, 32'd13);
    check("w4_accepted", acc, 32'd8);
    check("w4_ready_bad", rbad, 32'd0);
    check("w4_count", {23'd0, ld_count}, 32'd4);
    check("w4_err",   {31'd0, ld_err},   32'd0);
    read_chk("w4_mem0", 8'd0, 16'h1234);
    read_chk("w4_mem1", 8'd1, 16'h5678);
    read_chk("w4_mem2", 8'd2, 16'h9ABC);
    read_chk("w4_mem3", 8'd3, 16'hDEF0);

    // Odd byte count.
    src[0] = 8'hAA; src[1] = 8'hBB; src[2] = 8'hCC;
    do_load(3, 1'b1, 1'b0, hold, acc, rbad, e0);
    check("odd_hold",  hold, 32'd6);
    check("odd_count", {23'd0, ld_count}, 32'd2);
    check("odd_err",   {31'd0, ld_err},   32'd1);
    read_chk("odd_mem0", 8'd0, 16'hAABB);
    read_chk("odd_mem1", 8'd1, 16'hCC00);

    // Throttled source, same four words.
    src[0] = 8'h12; src[1] = 8'h34; src[2] = 8'h56; src[3] = 8'h78;
    src[4] = 8'h9A; src[5] = 8'hBC; src[6] = 8'hDE; src[7] = 8'hF0;
    do_load(8, 1'b1, 1'b1, hold, acc, rbad, e0);
    check("thr_err_cleared", {31'd0, e0}, 32'd0);
    check("thr_accepted", acc, 32'd8);
    check("thr_ready_bad", rbad, 32'd0);
    check("thr_count", {23'd0, ld_count}, 32'd4);
    check("thr_err",   {31'd0, ld_err},   32'd0);
    read_chk("thr_mem0", 8'd0, 16'h1234);
    read_chk("thr_mem1", 8'd1, 16'h5678);
    read_chk("thr_mem2", 8'd2, 16'h9ABC);
    read_chk("thr_mem3", 8'd3, 16'hDEF0);

    // Overflow: 514 bytes with no ld_last.
    for (int i = 0; i < 600; i++) src[i] = 8'(i * 37 + 5);
    do_load(514, 1'b0, 1'b0, hold, acc, rbad, e0);
    check("ovf_hold",     hold, 32'd769);
    check("ovf_accepted", acc, 32'd512);
    check("ovf_count", {23'd0, ld_count}, 32'd256);
    check("ovf_err",   {31'd0, ld_err},   32'd1);
    ld_valid = 1'b1; ld_byte = src[512];
    for (int k = 0; k < 3; k++) begin
      @(negedge ck);
      #1;
      check($sformatf("ovf_extra_ready%0d", k), {31'd0, ld_ready}, 32'd0);
    end
    ld_valid = 1'b0;
    check("ovf_count_after", {23'd0, ld_count}, 32'd256);
    read_chk("ovf_mem0",   8'd0,   {src[0],   src[1]});
    read_chk("ovf_mem128", 8'd128, {src[256], src[257]});
    read_chk("ovf_mem255", 8'd255, {src[510], src[511]});

    // Reset mid-load after two words, with an ignored CPU write and ld_start in LD_HI.
    @(negedge ck); ld_start = 1'b1;
    @(negedge ck); ld_start = 1'b0;
    ld_valid = 1'b1; ld_byte = 8'hA1;
    @(negedge ck); ld_byte = 8'hB2;
    @(negedge ck); ld_valid = 1'b0;
    @(negedge ck); ld_valid = 1'b1; ld_byte = 8'hC3;
    @(negedge ck); ld_byte = 8'hD4;
    @(negedge ck); ld_valid = 1'b0;
    @(negedge ck);
    ce = 1'b1; we = 1'b1; address = 8'd0; dataW = 16'hFFFF; ld_start = 1'b1;
    #1;
    check("mid_hold",  {31'd0, cpu_hold}, 32'd1);
    check("mid_ready", {31'd0, ld_ready}, 32'd1);
    check("mid_count", {23'd0, ld_count}, 32'd2);
    @(negedge ck);
    we = 1'b0; ld_start = 1'b0;
    #1;
    check("mid_no_cpu_write", {16'd0, dataR}, 32'h0000A1B2);
    check("mid_start_ignored", {23'd0, ld_count}, 32'd2);
    rst = 1'b1; ld_valid = 1'b1; ld_byte = 8'hEE;
    @(negedge ck);
    rst = 1'b0; ld_valid = 1'b0; ce = 1'b0;
    #1;
    check("mid_rst_hold",  {31'd0, cpu_hold}, 32'd0);
    check("mid_rst_ready", {31'd0, ld_ready}, 32'd0);
    check("mid_rst_count", {23'd0, ld_count}, 32'd0);
    check("mid_rst_err",   {31'd0, ld_err},   32'd0);
    read_chk("mid_mem0", 8'd0, 16'hA1B2);
    read_chk("mid_mem1", 8'd1, 16'hC3D4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nano_mem_loader.md
# nano_mem_loader

Memory responder for the NanoCPU bus: a 256×16 single-port RAM answering the CPU's `address/dataR/dataW/ce/we` interface, plus a byte-stream program loader. The loader fills the RAM from address 0 while holding the CPU in reset through `cpu_hold`, then releases it. It sits between the CPU top level and an external byte source (UART receiver or testbench).

## Interface
Parameters:
- `ADDR_W`, 8: CPU address width; RAM depth is 2**ADDR_W.
- `DATA_W`, 16: word width. It must equal 2×8, because the loader assembles two bytes per word.

Ports:
- `ck`  in  1  clock. Everything is on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `address`  in  ADDR_W  CPU word address.
- `dataW`  in  DATA_W  CPU write data.
- `dataR`  out  DATA_W  CPU read data.
- `ce`  in  1  CPU chip enable.
- `we`  in  1  CPU write enable. It is only qualified when `ce`=1.
- `ld_start`  in  1  single-cycle pulse that begins a load.
- `ld_valid`  in  1  the loader byte is valid.
- `ld_byte`  in  8  loader byte. High byte is sent first.
- `ld_last`  in  1  marks the final byte of the stream. Qualified by `ld_valid`.
- `ld_ready`  out  1  the block accepts a byte.
- `cpu_hold`  out  1  drives the CPU's `rst` (OR'd at the top level).
- `ld_count`  out  ADDR_W+1  number of words written by the current or last load.
- `ld_err`  out  1  sticky flag: odd byte count or overflow.

## Operation
- **CPU port:**
  - `dataR = mem[address]` combinationally when `ce`=1, and 0 when `ce`=0.
  - Write: `mem[address] <= dataW` on the edge where `ce & we` and the state is RUN.
  - In all other states, CPU writes are ignored.
- **FSM states:** RUN, LD_HI, LD_LO, LD_WR, RELEASE.
  - **RUN:** `ld_ready`=0 and `cpu_hold`=0. When `ld_start`=1, go to LD_HI, and clear ptr, `ld_count` and `ld_err`. A CPU write in that same cycle still completes.
  - **LD_HI:** `ld_ready`=1 and `cpu_hold`=1.
    - On `ld_valid`, capture hi=`ld_byte`.
    - If `ld_last`=1: set lo=0x00, set `ld_err`, set the last flag, and go to LD_WR.
    - Otherwise go to LD_LO.
  - **LD_LO:** `ld_ready`=1. On `ld_valid`, capture lo=`ld_byte`, latch `ld_last` into the last flag, and go to LD_WR.
  - **LD_WR:** `ld_ready`=0.
    - Write `mem[ptr] <= {hi,lo}`, then increment ptr and `ld_count`.
    - If the last flag is set, or ptr was 2**ADDR_W−1, go to RELEASE. Otherwise go to LD_HI.
  - **RELEASE:** `ld_ready`=0 and `cpu_hold`=1 for exactly one cycle, then go to RUN.
- **Overflow:** if the memory fills (ptr = 255 written) without `ld_last`, set `ld_err`. Bytes offered after that are not accepted, because `ld_ready`=0 in RUN.
- **Byte handshake:** a byte transfers only on an edge with `ld_valid & ld_ready`. The source must hold `ld_byte` and `ld_last` stable while `ld_valid`=1 and `ld_ready`=0.
- **`ld_start` outside RUN:** ignored.
- **Reset:**
  - state=RUN, `ld_ready`=0, `cpu_hold`=0, `ld_count`=0, `ld_err`=0, ptr=0, hi/lo=0.
  - RAM contents are not cleared.
  - `rst` wins over `ld_start`, `ld_valid` and CPU writes in the same cycle.
  - A reset mid-load abandons the load. Words already written stay in the RAM.
- **Width rules:**
  - ptr is ADDR_W bits; the overflow check is on the pre-increment value 8'hFF.
  - `ld_count` is ADDR_W+1 bits so that 256 is representable.

## Timing
- **CPU read latency:** 0 cycles (combinational). The CPU latches `dataR` at the end of its FETCH/LD cycle.
- **Read-during-write, same address:** `dataR` shows the old value in the write cycle and the new value from the next cycle.
- **Load throughput:** minimum 3 cycles per word (LD_HI, LD_LO, LD_WR) with `ld_valid` held high.
- **Total hold:** `cpu_hold` goes high on the edge after `ld_start` and stays high for ≥ 3N+1 cycles for N words. It deasserts on the edge that leaves RELEASE.
- **Data visibility:** a word written in LD_WR is readable on `dataR` in the following cycle.

## Structure
- **Package `nano_pkg`:** holds `LdStateType` (enum logic [2:0]: RUN, LD_HI, LD_LO, LD_WR, RELEASE) and the constants `NANO_ADDR_W`=8 and `NANO_DATA_W`=16.
- **Sub-module `nano_ram`:** parameterised RAM with synchronous write and combinational read, one write port.
  - The write-port mux selects the CPU or the loader: the loader in LD_WR, the CPU in RUN.
  - FSM, ptr, `ld_count` and `ld_err` stay in the top module.

## Test plan
- **CPU access:** CPU writes 0xBEEF to 0x10 (`ce=we=1`), then reads with `ce=1`, `we=0` → `dataR`=0xBEEF the following cycle. With `ce=0` → `dataR`=0.
- **Four-word load:** `ld_start`, then bytes 12 34 56 78 9A BC DE F0, with `ld_last` on F0 and `ld_valid` held high.
  - mem[0..3] = 0x1234, 0x5678, 0x9ABC, 0xDEF0.
  - `ld_count`=4, `ld_err`=0.
  - `cpu_hold` high for 13 cycles.
- **Throttled source:** `ld_valid` toggles every other cycle → identical RAM contents. No byte is lost or duplicated; `ld_ready` is 0 in LD_WR and RELEASE.
- **Odd byte count:** bytes AA BB CC with `ld_last` on CC → mem[1]=0xCC00, `ld_count`=2, `ld_err`=1. `ld_err` clears on the next `ld_start`.
- **Overflow:** 514 bytes without `ld_last` → 256 words written, `ld_err`=1, `ld_count`=256. The state returns to RUN with `ld_ready`=0 and the extra bytes are not accepted.
- **Reset mid-load:** `rst` after 2 words → state RUN, `cpu_hold`=0, `ld_count`=0. mem[0..1] keep the loaded values. A CPU write attempted during LD_HI does not modify the RAM.
